// File: rtl/lut_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encoding and parameter bounds.
package lut_sweeper_pkg;

    // Largest supported number of function inputs (64-entry table).
    localparam int unsigned N_IN_MAX = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Table width for a given input count.
    function automatic int unsigned tt_width(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

endpackage

// File: rtl/lut_sweeper_if.sv
// Beat stream carrying (index, function value) pairs from the sweeper to its consumer.
interface lut_sweeper_if #(
    parameter int unsigned N_IN = 3
);
    logic            out_valid;
    logic            out_ready;
    logic [N_IN-1:0] out_idx;
    logic            out_s;

    modport master (
        output out_valid,
        output out_idx,
        output out_s,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        input  out_s,
        output out_ready
    );
endinterface

// File: rtl/lut_sweeper_tt_mux.sv
// Combinational truth-table read: s = tt[idx]. Shared with the table checker.
module tt_mux #(
    parameter int unsigned N_IN = 3
) (
    input  logic [(2**N_IN)-1:0] tt,
    input  logic [N_IN-1:0]      idx,
    output logic                 s
);

    // Plain mux from registered sources, so s settles once per clock.
    assign s = tt[idx];

endmodule

// File: rtl/lut_sweeper.sv
// Truth-table sweeper: holds a loadable table, walks every input vector on start and
// streams one beat per vector, accumulating the number of minterms that evaluate to 1.
module lut_sweeper
    import lut_sweeper_pkg::*;
#(
    parameter int unsigned  N_IN    = 3,
    parameter logic [63:0]  TT_INIT = 64'h44,
    localparam int unsigned TT_W    = 2 ** N_IN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [TT_W-1:0] tt_in,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [N_IN:0]   ones_count,
    lut_sweeper_if.master   out_if
);

    // Reset table is TT_INIT truncated (or zero-extended) to the table width.
    localparam logic [TT_W-1:0] TT_RST   = TT_INIT[TT_W-1:0];
    localparam logic [N_IN-1:0] IDX_LAST = N_IN'(tt_width(N_IN) - 1);

    state_e          state_q, state_d;
    logic [TT_W-1:0] tt_q, tt_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [N_IN:0]   ones_q, ones_d;
    logic            s;
    logic            hs;

    tt_mux #(
        .N_IN (N_IN)
    ) u_tt_mux (
        .tt  (tt_q),
        .idx (idx_q),
        .s   (s)
    );

    assign hs = (state_q == ST_SWEEP) && out_if.out_ready;

    // Next-state: command decode in IDLE, beat advance in SWEEP, single-cycle DONE.
    always_comb begin
        state_d = state_q;
        tt_d    = tt_q;
        idx_d   = idx_q;
        ones_d  = ones_q;
        case (state_q)
            ST_IDLE: begin
                // A simultaneous load is visible to the sweep it starts.
                if (load) begin
                    tt_d = tt_in;
                end
                if (start) begin
                    ones_d  = '0;
                    idx_d   = '0;
                    state_d = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                if (hs) begin
                    ones_d = ones_q + {{N_IN{1'b0}}, s};
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any sweep and restores the power-on table.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tt_q    <= TT_RST;
            idx_q   <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            tt_q    <= tt_d;
            idx_q   <= idx_d;
            ones_q  <= ones_d;
        end
    end

    // Outputs decode directly from registered state.
    always_comb begin
        busy             = (state_q != ST_IDLE);
        done             = (state_q == ST_DONE);
        ones_count       = ones_q;
        out_if.out_valid = (state_q == ST_SWEEP);
        out_if.out_idx   = idx_q;
        out_if.out_s     = s;
    end

endmodule
